data_mem_port: RTL and testbench
================================

// Module: data_mem_port
// PURPOSE
//  Memory-stage responder for the load/store requests raised by the decode controller (MEM_READ_EN/MEM_WRITE_EN + FUNC3).
//  Handles byte/half/word alignment, load sign/zero extension and store byte-enables.
//  Runs a word-wide request/ack handshake to the backing data memory and stalls the pipeline via BUSY_WAIT until done.
// PARAMETERS
//  TIMEOUT  0  max ACCESS cycles awaiting M_ACK (1..255); 0 = wait forever
// PORTS
//  CLK           in   1   clock; all state on rising edge
//  RESET         in   1   asynchronous, active-high reset
//  MEM_READ_EN   in   1   load request from MEM stage
//  MEM_WRITE_EN  in   1   store request from MEM stage
//  FUNC3         in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  ADDRESS       in   32  byte address (ALU result)
//  WRITE_DATA    in   32  store data (rs2)
//  READ_DATA     out  32  extended load result
//  BUSY_WAIT     out  1   pipeline stall request
//  MISALIGNED    out  1   one-cycle pulse: misaligned access rejected
//  BUS_ERROR     out  1   one-cycle pulse: access timed out
//  M_REQ         out  1   backing-memory request, held until M_ACK
//  M_WE          out  1   1 = write transaction
//  M_ADDR        out  30  word address (ADDRESS[31:2])
//  M_WDATA       out  32  lane-replicated store data
//  M_BE          out  4   byte enables (write only; 1111 on reads)
//  M_RDATA       in   32  read word, valid with M_ACK
//  M_ACK         in   1   transaction complete
// BEHAVIOUR
//  Reset: state IDLE, counter 0; every output 0, including READ_DATA and latched M_* regs.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: when an enable is high and the access is aligned, BUSY_WAIT=1 combinationally the same cycle.
//    Also latch addr/func3/data/we and go to ACCESS. MEM_WRITE_EN wins if both enables are high. M_ACK ignored.
//  Misaligned (H/HU with ADDRESS[0]=1; W with ADDRESS[1:0]!=0): stay IDLE, no M_REQ, BUSY_WAIT=0.
//    MISALIGNED=1 for that cycle; READ_DATA unchanged.
//  ACCESS: M_REQ=1, BUSY_WAIT=1, M_* driven from latched regs and stable throughout.
//    M_ACK=1 -> capture and go to DONE. Minimum stall is 2 cycles (ACK in 1st ACCESS cycle).
//  Timeout (TIMEOUT>0): counter counts ACCESS cycles. TIMEOUT cycles with no ACK -> DONE with BUS_ERROR=1 in DONE.
//    READ_DATA is set to 0 on a timed-out load.
//  DONE: BUSY_WAIT=0, inputs ignored (the pipeline advances at this edge), then IDLE next cycle.
//    Back-to-back accesses therefore cost one IDLE cycle between them.
//  READ_DATA: registered at ACK for loads; held through writes and idle cycles.
//  Load extension uses latched addr[1:0]. B/BU select lane addr[1:0]; H/HU select lane addr[1].
//    B/H sign-extend, BU/HU zero-extend.
//  Store: B -> M_WDATA={4{d[7:0]}}, M_BE=0001<<addr[1:0]; H -> {2{d[15:0]}}, 0011<<{addr[1],0}; W -> d, 1111.
//  Undefined FUNC3 (011,110,111; 100/101 on stores) is handled as W.
//  Async RESET mid-ACCESS: M_REQ and BUSY_WAIT drop immediately; a later stray M_ACK is ignored in IDLE.
// STRUCTURE
//  Shared package/header mem_defs.vh: FUNC3 width encodings, FSM state encodings, M_BE patterns.
//  One combinational sub-module dmem_load_align (word, addr[1:0], func3 -> 32b extended value).
//  The FSM, latches, timeout counter and store lane logic stay in data_mem_port.
// TESTING
//  LW 0x100, M_RDATA=0xDEADBEEF, ACK on 3rd ACCESS cycle -> BUSY_WAIT high 4 cycles, then READ_DATA=0xDEADBEEF in DONE.
//  Word 0x80FF1234: LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080; LH 0x102 -> 0xFFFF80FF; LHU 0x100 -> 0x00001234.
//  SB 0x101 data 0x000000AB -> M_WE=1, M_ADDR=0x40, M_BE=0010, M_WDATA=0xABABABAB; SH 0x102 0x1234 -> M_BE=1100.
//  LW 0x102 -> MISALIGNED 1 cycle, no M_REQ, BUSY_WAIT=0, READ_DATA unchanged.
//  TIMEOUT=8, M_ACK held 0 -> M_REQ 8 cycles, then DONE with BUS_ERROR=1, BUSY_WAIT=0, READ_DATA=0.
//  RESET pulsed in 2nd ACCESS cycle -> M_REQ/BUSY_WAIT/READ_DATA 0 at once; M_ACK 2 cycles later causes no transition.

Source files
------------

// File: rtl/data_mem_port_pkg.sv
// Shared definitions for the data-memory port.
//   - FUNC3 access-width encodings (RISC-V load/store subset)
//   - FSM state encodings
//   - base byte-enable patterns
//   - access_size(): maps FUNC3 + direction onto an effective width
package data_mem_port_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    // Unsigned variants have no meaning for stores, and undefined codes
    // fall back to a full word in both directions.
    function automatic size_e access_size(input logic [2:0] f3, input logic we);
        size_e sz;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_W:    sz = SZ_W;
            F3_BU:   sz = we ? SZ_W : SZ_B;
            F3_HU:   sz = we ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment / extension (purely combinational).
//   word_i  : 32-bit word returned by the backing memory
//   addr_i  : byte offset within the word
//   func3_i : load FUNC3 (B/H sign-extend, BU/HU zero-extend, else word)
//   data_o  : extended load result
module dmem_load_align
    import data_mem_port_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        case (func3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// Memory-stage load/store responder.
// Accepts MEM_READ_EN / MEM_WRITE_EN + FUNC3 from the pipeline, checks
// alignment, runs a word-wide REQ/ACK transaction to the backing memory
// and stalls the pipeline through BUSY_WAIT until the access completes.
//   CLK, RESET                  : clock, async active-high reset
//   MEM_READ_EN, MEM_WRITE_EN   : request (write wins if both)
//   FUNC3, ADDRESS, WRITE_DATA  : access width, byte address, store data
//   READ_DATA                   : registered, extended load result
//   BUSY_WAIT                   : pipeline stall
//   MISALIGNED, BUS_ERROR       : rejected-access / timeout indications
//   M_REQ/M_WE/M_ADDR/M_WDATA/M_BE, M_RDATA/M_ACK : backing-memory bus
module data_mem_port
    import data_mem_port_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ_EN,
    input  logic        MEM_WRITE_EN,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY_WAIT,
    output logic        MISALIGNED,
    output logic        BUS_ERROR,
    output logic        M_REQ,
    output logic        M_WE,
    output logic [29:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_BE,
    input  logic [31:0] M_RDATA,
    input  logic        M_ACK
);

    // Counter value of the last ACCESS cycle before giving up.
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req, mis, start;
    size_e       sz;
    logic [31:0] st_wdata, ld_value;
    logic [3:0]  st_be;

    dmem_load_align u_align (
        .word_i  (M_RDATA),
        .addr_i  (addr_q[1:0]),
        .func3_i (f3_q),
        .data_o  (ld_value)
    );

    // Request decode, alignment check and store lane placement.
    always_comb begin
        req   = MEM_READ_EN | MEM_WRITE_EN;
        sz    = access_size(FUNC3, MEM_WRITE_EN);
        mis   = req && ((sz == SZ_H && ADDRESS[0]) ||
                        (sz == SZ_W && ADDRESS[1:0] != 2'b00));
        start = (state_q == ST_IDLE) && req && !mis;

        st_be    = BE_W;
        st_wdata = '0;
        if (MEM_WRITE_EN) begin
            case (sz)
                SZ_B: begin
                    st_wdata = {4{WRITE_DATA[7:0]}};
                    st_be    = BE_B << ADDRESS[1:0];
                end
                SZ_H: begin
                    st_wdata = {2{WRITE_DATA[15:0]}};
                    st_be    = BE_H << {ADDRESS[1], 1'b0};
                end
                default: begin
                    st_wdata = WRITE_DATA;
                    st_be    = BE_W;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    we_d    = MEM_WRITE_EN;
                    addr_d  = ADDRESS;
                    f3_d    = FUNC3;
                    wdata_d = st_wdata;
                    be_d    = st_be;
                end
            end
            ST_ACCESS: begin
                // An ACK in the final allowed cycle still completes normally.
                if (M_ACK) begin
                    state_d = ST_DONE;
                    if (!we_q) rdata_d = ld_value;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // Combinational outputs are gated by RESET so they drop while it is held,
    // even though request inputs may still be asserted.
    assign BUSY_WAIT  = !RESET && (start || state_q == ST_ACCESS);
    assign MISALIGNED = !RESET && (state_q == ST_IDLE) && mis;
    assign BUS_ERROR  = (state_q == ST_DONE) && err_q;
    assign M_REQ      = (state_q == ST_ACCESS);
    assign M_WE       = we_q;
    assign M_ADDR     = addr_q[31:2];
    assign M_WDATA    = wdata_q;
    assign M_BE       = be_q;
    assign READ_DATA  = rdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
module tb_data_mem_port;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ_EN, MEM_WRITE_EN;
    logic [2:0]  FUNC3;
    logic [31:0] ADDRESS, WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSY_WAIT, MISALIGNED, BUS_ERROR;
    logic        M_REQ, M_WE;
    logic [29:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [3:0]  M_BE;
    logic [31:0] M_RDATA;
    logic        M_ACK;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] rd_model;

    always #5 CLK = ~CLK;

    data_mem_port #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .MEM_READ_EN(MEM_READ_EN), .MEM_WRITE_EN(MEM_WRITE_EN),
        .FUNC3(FUNC3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .READ_DATA(READ_DATA), .BUSY_WAIT(BUSY_WAIT),
        .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR),
        .M_WDATA(M_WDATA), .M_BE(M_BE),
        .M_RDATA(M_RDATA), .M_ACK(M_ACK)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access. Bus expectations and load results are queued when
    // the request is driven and popped when the DUT presents them.
    // ack_at = ACCESS cycle (1-based) carrying M_ACK, 0 = never.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] word, input int ack_at,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rd, input int exp_busy,
                              input logic exp_err);
        bus_exp_t be_exp;
        logic [31:0] rexp;
        int busy;
        bit first, done;
        bus_q.push_back('{we: wr, addr: addr[31:2], be: exp_be, wdata: exp_wdata});
        rd_q.push_back(exp_rd);
        @(negedge CLK);
        MEM_READ_EN = rd; MEM_WRITE_EN = wr; FUNC3 = f3; ADDRESS = addr; WRITE_DATA = wd;
        #1 chk("busy_same_cycle", {31'd0, BUSY_WAIT}, 32'd1);
        busy = 1; first = 0; done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            MEM_READ_EN = 0; MEM_WRITE_EN = 0; M_ACK = 0;
            if (!BUSY_WAIT) begin done = 1; break; end
            busy++;
            if (!first) begin
                first  = 1;
                be_exp = bus_q.pop_front();
                chk("m_we",   {31'd0, M_WE}, {31'd0, be_exp.we});
                chk("m_addr", {2'd0, M_ADDR}, {2'd0, be_exp.addr});
                chk("m_be",   {28'd0, M_BE}, {28'd0, be_exp.be});
                if (be_exp.we) chk("m_wdata", M_WDATA, be_exp.wdata);
            end
            if (busy - 1 == ack_at) begin M_ACK = 1; M_RDATA = word; end
        end
        chk("access_bound", {31'd0, done}, 32'd1);
        chk("busy_cycles", busy, exp_busy);
        chk("done_mreq", {31'd0, M_REQ}, 32'd0);
        chk("bus_error", {31'd0, BUS_ERROR}, {31'd0, exp_err});
        rexp = rd_q.pop_front();
        if (!wr) rd_model = rexp;
        chk("read_data", READ_DATA, rd_model);
    endtask

    initial begin
        RESET = 1; MEM_READ_EN = 0; MEM_WRITE_EN = 0; FUNC3 = 0;
        ADDRESS = 0; WRITE_DATA = 0; M_RDATA = 0; M_ACK = 0; rd_model = 0;
        repeat (2) @(negedge CLK);
        chk("rst_read_data", READ_DATA, 32'd0);
        chk("rst_busy", {31'd0, BUSY_WAIT}, 32'd0);
        chk("rst_mreq", {31'd0, M_REQ}, 32'd0);
        chk("rst_mbus", {M_WE, M_ADDR, 1'b0}, 32'd0);
        chk("rst_wdata_be", M_WDATA | {28'd0, M_BE}, 32'd0);
        chk("rst_flags", {30'd0, MISALIGNED, BUS_ERROR}, 32'd0);
        RESET = 0;

        // Loads: rd wr f3 addr wd word ack be wdata rd busy err
        run_access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 4'hF, 0, 32'hDEADBEEF, 4, 0);
        run_access(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1, 4'hF, 0, 32'hFFFFFF80, 2, 0);
        run_access(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 2, 4'hF, 0, 32'h00000080, 3, 0);
        run_access(1, 0, 3'b001, 32'h102, 0, 32'h80FF1234, 1, 4'hF, 0, 32'hFFFF80FF, 2, 0);
        run_access(1, 0, 3'b101, 32'h100, 0, 32'h80FF1234, 1, 4'hF, 0, 32'h00001234, 2, 0);

        // Misaligned LW and LH are rejected without a bus request.
        @(negedge CLK);
        MEM_READ_EN = 1; FUNC3 = 3'b010; ADDRESS = 32'h102;
        #1;
        chk("mis_lw_flag", {31'd0, MISALIGNED}, 32'd1);
        chk("mis_lw_busy", {31'd0, BUSY_WAIT}, 32'd0);
        @(negedge CLK);
        MEM_READ_EN = 0;
        chk("mis_lw_noreq", {31'd0, M_REQ}, 32'd0);
        chk("mis_lw_rdata", READ_DATA, rd_model);
        MEM_READ_EN = 1; FUNC3 = 3'b001; ADDRESS = 32'h101;
        #1 chk("mis_lh_flag", {31'd0, MISALIGNED}, 32'd1);
        @(negedge CLK);
        MEM_READ_EN = 0;
        chk("mis_lh_noreq", {31'd0, M_REQ}, 32'd0);
        #1 chk("mis_clear", {31'd0, MISALIGNED}, 32'd0);

        // Stores; READ_DATA must hold across them. Last one has both enables.
        run_access(0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 1, 4'b0010, 32'hABABABAB, 0, 2, 0);
        run_access(0, 1, 3'b001, 32'h102, 32'h00001234, 0, 2, 4'b1100, 32'h12341234, 0, 3, 0);
        run_access(1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 1, 4'b1111, 32'hCAFEF00D, 0, 2, 0);

        // Async reset in the 2nd ACCESS cycle; a later stray ACK is ignored.
        @(negedge CLK);
        MEM_READ_EN = 1; FUNC3 = 3'b010; ADDRESS = 32'h200;
        @(negedge CLK);
        MEM_READ_EN = 0;
        @(negedge CLK);
        RESET = 1;
        #1;
        rd_model = 0;
        chk("arst_mreq", {31'd0, M_REQ}, 32'd0);
        chk("arst_busy", {31'd0, BUSY_WAIT}, 32'd0);
        chk("arst_rdata", READ_DATA, 32'd0);
        @(negedge CLK);
        RESET = 0;
        @(negedge CLK);
        M_ACK = 1; M_RDATA = 32'h55AA55AA;
        @(negedge CLK);
        M_ACK = 0;
        chk("stray_ack_mreq", {31'd0, M_REQ}, 32'd0);
        chk("stray_ack_busy", {31'd0, BUSY_WAIT}, 32'd0);
        chk("stray_ack_rdata", READ_DATA, 32'd0);

        // Minimum stall, then a timeout with ACK held low.
        run_access(1, 0, 3'b010, 32'h100, 0, 32'h13579BDF, 1, 4'hF, 0, 32'h13579BDF, 2, 0);
        run_access(1, 0, 3'b010, 32'h300, 0, 32'hFFFFFFFF, 0, 4'hF, 0, 32'h00000000, 9, 1);
        @(negedge CLK);
        chk("bus_error_pulse", {31'd0, BUS_ERROR}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
